// File: rtl/kgprisc_pkg.sv
// Shared opcode/func encodings, FSM states and ALU operations for kgprisc_mc.
package kgprisc_pkg;

   localparam logic [5:0] OP_R    = 6'd0;
   localparam logic [5:0] OP_ADDI = 6'd1;
   localparam logic [5:0] OP_LD   = 6'd2;
   localparam logic [5:0] OP_ST   = 6'd3;
   localparam logic [5:0] OP_BZ   = 6'd4;
   localparam logic [5:0] OP_B    = 6'd5;
   localparam logic [5:0] OP_BL   = 6'd6;
   localparam logic [5:0] OP_BR   = 6'd7;
   localparam logic [5:0] OP_HALT = 6'd63;

   localparam logic [5:0] F_ADD = 6'd0;
   localparam logic [5:0] F_SUB = 6'd1;
   localparam logic [5:0] F_AND = 6'd2;
   localparam logic [5:0] F_XOR = 6'd3;
   localparam logic [5:0] F_SLL = 6'd4;
   localparam logic [5:0] F_SRL = 6'd5;

   typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

   typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_XOR, ALU_SLL, ALU_SRL} alu_op_t;

endpackage

// File: rtl/kgprisc_alu.sv
// Combinational ALU shared by every instruction; zero flag drives BZ.
module kgprisc_alu
   import kgprisc_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  alu_op_t         op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic [XLEN-1:0] y,
   output logic            zero
);

   // Result select; shifts use the low five bits of b as the amount.
   always_comb begin
      y = '0;
      case (op)
         ALU_ADD: y = a + b;
         ALU_SUB: y = a - b;
         ALU_AND: y = a & b;
         ALU_XOR: y = a ^ b;
         ALU_SLL: y = a << b[4:0];
         ALU_SRL: y = a >> b[4:0];
         default: y = a + b;
      endcase
      zero = (y == '0);
   end

endmodule

// File: rtl/kgprisc_mc.sv
// Multi-cycle KGPRISC core: external valid/ready instruction and data ports,
// one ALU pass per instruction, halt/trap, r0 hardwired to zero.
// Assumes XLEN >= IAW and XLEN >= DAW (BR target and data address come from XLEN values).
module kgprisc_mc
   import kgprisc_pkg::*;
#(
   parameter int unsigned XLEN     = 32,
   parameter int unsigned NREGS    = 32,
   parameter int unsigned IAW      = 10,
   parameter int unsigned DAW      = 10,
   parameter int unsigned LINK_REG = NREGS - 1
) (
   input  logic            clk,
   input  logic            reset,
   output logic            imem_req,
   output logic [IAW-1:0]  imem_addr,
   input  logic [31:0]     imem_rdata,
   input  logic            imem_ready,
   output logic            dmem_req,
   output logic            dmem_we,
   output logic [DAW-1:0]  dmem_addr,
   output logic [XLEN-1:0] dmem_wdata,
   input  logic [XLEN-1:0] dmem_rdata,
   input  logic            dmem_ready,
   output logic            retire,
   output logic [IAW-1:0]  pc_out,
   output logic            halted,
   output logic            trap
);

   localparam int unsigned RW = $clog2(NREGS);

   state_t          state;
   logic [IAW-1:0]  pc, npc_q, next_pc, pc_inc, off16, off21;
   logic [31:0]     ir;
   logic [XLEN-1:0] a_q, b_q, res_q, imm16_x, alu_b, alu_y, link_val;
   logic [XLEN-1:0] rf [NREGS];
   logic [5:0]      op, func;
   logic [RW-1:0]   rs_idx, rt_idx, rd_idx;
   logic            illegal, writes_rd, alu_zero;
   alu_op_t         alu_op;

   assign op        = ir[31:26];
   assign func      = ir[5:0];
   assign rs_idx    = ir[21 +: RW];
   assign rt_idx    = ir[16 +: RW];
   assign imem_addr = pc;
   assign pc_out    = pc;
   // ST commits in MEM on the data handshake; everything else commits in WB.
   assign retire    = (state == WB) || (state == MEM && dmem_we && dmem_ready);

   // Immediate extension and sequential pc.
   always_comb begin
      imm16_x  = XLEN'($signed(ir[15:0]));
      off16    = IAW'($signed(ir[15:0]));
      off21    = IAW'($signed(ir[20:0]));
      pc_inc   = pc + IAW'(1);
      link_val = XLEN'(pc_inc);
   end

   // Legality, destination register and write-enable decode.
   always_comb begin
      illegal   = 1'b0;
      writes_rd = 1'b0;
      rd_idx    = rt_idx;
      case (op)
         OP_R: begin
            illegal   = (func > F_SRL);
            writes_rd = 1'b1;
            rd_idx    = rs_idx;
         end
         OP_ADDI, OP_LD: writes_rd = 1'b1;
         OP_BL: begin
            writes_rd = 1'b1;
            rd_idx    = RW'(LINK_REG);
         end
         OP_ST, OP_BZ, OP_B, OP_BR, OP_HALT: illegal = 1'b0;
         default: illegal = 1'b1;
      endcase
   end

   // ALU operand and operation selection.
   always_comb begin
      alu_op = ALU_ADD;
      alu_b  = imm16_x;
      case (op)
         OP_R: begin
            alu_b = b_q;
            case (func)
               F_SUB:   alu_op = ALU_SUB;
               F_AND:   alu_op = ALU_AND;
               F_XOR:   alu_op = ALU_XOR;
               F_SLL:   alu_op = ALU_SLL;
               F_SRL:   alu_op = ALU_SRL;
               default: alu_op = ALU_ADD;
            endcase
         end
         OP_BZ:   alu_b = '0;
         default: alu_b = imm16_x;
      endcase
   end

   kgprisc_alu #(.XLEN(XLEN)) u_alu (
      .op   (alu_op),
      .a    (a_q),
      .b    (alu_b),
      .y    (alu_y),
      .zero (alu_zero)
   );

   // Next-pc selection evaluated in EXEC.
   always_comb begin
      next_pc = pc_inc;
      case (op)
         OP_BZ:       if (alu_zero) next_pc = pc_inc + off16;
         OP_B, OP_BL: next_pc = pc_inc + off21;
         OP_BR:       next_pc = a_q[IAW-1:0];
         default:     next_pc = pc_inc;
      endcase
   end

   // Register file write in WB; r0 is never written so it always reads zero.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rf <= '{default: '0};
      end else if (state == WB && writes_rd && rd_idx != '0) begin
         rf[rd_idx] <= res_q;
      end
   end

   // Instruction sequencer with registered request and status outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= FETCH;
         pc         <= '0;
         npc_q      <= '0;
         ir         <= '0;
         a_q        <= '0;
         b_q        <= '0;
         res_q      <= '0;
         imem_req   <= 1'b0;
         dmem_req   <= 1'b0;
         dmem_we    <= 1'b0;
         dmem_addr  <= '0;
         dmem_wdata <= '0;
         halted     <= 1'b0;
         trap       <= 1'b0;
      end else begin
         case (state)
            FETCH: begin
               if (imem_req && imem_ready) begin
                  ir       <= imem_rdata;
                  imem_req <= 1'b0;
                  state    <= DECODE;
               end else begin
                  imem_req <= 1'b1;
               end
            end
            DECODE: begin
               a_q <= rf[rs_idx];
               b_q <= rf[rt_idx];
               if (illegal) begin
                  halted <= 1'b1;
                  trap   <= 1'b1;
                  state  <= HALT;
               end else if (op == OP_HALT) begin
                  halted <= 1'b1;
                  state  <= HALT;
               end else begin
                  state <= EXEC;
               end
            end
            EXEC: begin
               res_q <= (op == OP_BL) ? link_val : alu_y;
               npc_q <= next_pc;
               if (op == OP_LD || op == OP_ST) begin
                  dmem_req   <= 1'b1;
                  dmem_we    <= (op == OP_ST);
                  dmem_addr  <= alu_y[DAW-1:0];
                  dmem_wdata <= b_q;
                  state      <= MEM;
               end else begin
                  state <= WB;
               end
            end
            MEM: begin
               if (dmem_ready) begin
                  dmem_req <= 1'b0;
                  dmem_we  <= 1'b0;
                  if (dmem_we) begin
                     pc       <= npc_q;
                     imem_req <= 1'b1;
                     state    <= FETCH;
                  end else begin
                     res_q <= dmem_rdata;
                     state <= WB;
                  end
               end
            end
            WB: begin
               pc       <= npc_q;
               imem_req <= 1'b1;
               state    <= FETCH;
            end
            HALT:    state <= HALT;
            default: state <= HALT;
         endcase
      end
   end

endmodule

// File: tb/tb_kgprisc_mc.sv
// Self-checking bench for kgprisc_mc: behavioural memories with programmable
// latency, retire scoreboard (pc and cycles since previous retire).
module tb_kgprisc_mc;
   import kgprisc_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req, imem_ready;
   logic [9:0]  imem_addr;
   logic [31:0] imem_rdata;
   logic        dmem_req, dmem_we, dmem_ready;
   logic [9:0]  dmem_addr;
   logic [31:0] dmem_wdata, dmem_rdata;
   logic        retire, halted, trap;
   logic [9:0]  pc_out;

   kgprisc_mc #(.XLEN(32), .NREGS(32), .IAW(10), .DAW(10), .LINK_REG(31)) dut (
      .clk(clk), .reset(reset),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
      .retire(retire), .pc_out(pc_out), .halted(halted), .trap(trap)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [9:0] pc;
      int         delta;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] imem [1024];
   logic [31:0] dmem [1024];
   int          n_tests = 0, n_fail = 0;
   int          cyc = 0, last_ret = 0, idelay = 0, ddelay = 0, icnt = 0, dcnt = 0, stab_err = 0;
   bit          started = 0, force_dr = 0;
   logic [9:0]  iaddr_l, daddr_l;
   logic [31:0] dwdata_l;
   logic        dwe_l;

   localparam logic [31:0] HALT_W = {6'd63, 26'd0};

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] enc_r(input int rs, input int rt, input int fn);
      logic [4:0] s, t; logic [5:0] f;
      s = rs[4:0]; t = rt[4:0]; f = fn[5:0];
      return {6'd0, s, t, 10'd0, f};
   endfunction

   function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input int imm);
      logic [5:0] o; logic [4:0] s, t; logic [15:0] i;
      o = op[5:0]; s = rs[4:0]; t = rt[4:0]; i = imm[15:0];
      return {o, s, t, i};
   endfunction

   function automatic logic [31:0] enc_j(input int op, input int imm);
      logic [5:0] o; logic [20:0] i;
      o = op[5:0]; i = imm[20:0];
      return {o, 5'd0, i};
   endfunction

   task automatic push(input int pc, input int delta);
      exp_t e;
      e.pc = pc[9:0];
      e.delta = delta;
      sb.push_back(e);
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Memory models: drive #1 after the edge, check request stability while waiting.
   always @(posedge clk) begin
      #1;
      if (imem_req) begin
         if (icnt == 0) iaddr_l = imem_addr;
         else if (imem_addr !== iaddr_l) stab_err++;
         if (icnt == idelay) begin
            imem_ready = 1'b1; imem_rdata = imem[imem_addr]; icnt = 0;
         end else begin
            imem_ready = 1'b0; icnt++;
         end
      end else begin
         imem_ready = 1'b0; icnt = 0;
      end
      if (dmem_req) begin
         if (dcnt == 0) begin
            daddr_l = dmem_addr; dwdata_l = dmem_wdata; dwe_l = dmem_we;
         end else if (dmem_addr !== daddr_l || dmem_wdata !== dwdata_l || dmem_we !== dwe_l) begin
            stab_err++;
         end
         if (dcnt == ddelay) begin
            dmem_ready = 1'b1; dcnt = 0;
            if (dmem_we) dmem[dmem_addr] = dmem_wdata;
            else dmem_rdata = dmem[dmem_addr];
         end else begin
            dmem_ready = 1'b0; dcnt++;
         end
      end else begin
         dmem_ready = 1'b0; dcnt = 0;
      end
      if (force_dr) dmem_ready = 1'b1;
   end

   // Retire monitor: pops the scoreboard on every commit.
   always @(negedge clk) begin
      exp_t e;
      if (reset) begin
         if (!started && imem_req) begin
            started  = 1;
            last_ret = cyc - 1;
         end
         if (retire) begin
            if (sb.size() == 0) begin
               check("sb_extra_retire", 64'd1, 64'd0);
            end else begin
               e = sb.pop_front();
               check("retire_pc", 64'(pc_out), 64'(e.pc));
               check("retire_delta", 64'(cyc - last_ret), 64'(e.delta));
            end
            last_ret = cyc;
         end
      end
   end

   task automatic start_reset();
      @(negedge clk);
      reset = 1'b0;
      sb.delete();
      started  = 0;
      stab_err = 0;
      for (int i = 0; i < 1024; i++) imem[i] = HALT_W;
   endtask

   task automatic release_reset(input int id, input int dd);
      idelay = id;
      ddelay = dd;
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic wait_halt(input int budget);
      int n = 0;
      while (!halted && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("halt_reached", 64'(halted), 64'd1);
      repeat (4) @(negedge clk);
      check("halt_no_ireq", 64'(imem_req), 64'd0);
      check("halt_no_dreq", 64'(dmem_req), 64'd0);
      check("sb_drained", 64'(sb.size()), 64'd0);
   endtask

   task automatic load_t1();
      imem[0] = enc_i(1, 0, 1, 5);
      imem[1] = enc_i(1, 0, 2, 7);
      imem[2] = enc_r(1, 2, 0);
   endtask

   initial begin
      int n;
      reset = 1'b0;
      imem_ready = 1'b0; dmem_ready = 1'b0;
      imem_rdata = '0;   dmem_rdata = '0;
      for (int i = 0; i < 1024; i++) dmem[i] = '0;

      // Reset values and zero-wait ALU program.
      start_reset();
      #1;
      check("rst_ireq", 64'(imem_req), 64'd0);
      check("rst_dreq", 64'(dmem_req), 64'd0);
      check("rst_retire", 64'(retire), 64'd0);
      check("rst_halted", 64'(halted), 64'd0);
      check("rst_trap", 64'(trap), 64'd0);
      check("rst_pc", 64'(pc_out), 64'd0);
      load_t1();
      push(0, 4); push(1, 4); push(2, 4);
      release_reset(0, 0);
      wait_halt(200);
      check("t1_r1", 64'(dut.rf[1]), 64'd12);
      check("t1_r2", 64'(dut.rf[2]), 64'd7);
      check("t1_trap", 64'(trap), 64'd0);
      check("t1_pc", 64'(pc_out), 64'd3);

      // Same program with 3-cycle fetch latency.
      start_reset();
      load_t1();
      push(0, 7); push(1, 7); push(2, 7);
      release_reset(3, 0);
      wait_halt(300);
      check("t2_r1", 64'(dut.rf[1]), 64'd12);
      check("t2_stable", 64'(stab_err), 64'd0);

      // Store/load with 2-cycle data latency, plus the remaining ALU ops.
      start_reset();
      imem[0]  = enc_i(1, 0, 4, 16);
      imem[1]  = enc_i(1, 0, 1, 'hDEAE);
      imem[2]  = enc_r(1, 4, 4);
      imem[3]  = enc_i(1, 0, 5, 'hBEEF);
      imem[4]  = enc_r(1, 5, 0);
      imem[5]  = enc_i(3, 0, 1, 4);
      imem[6]  = enc_i(2, 0, 3, 4);
      imem[7]  = enc_i(1, 0, 6, 'h00F0);
      imem[8]  = enc_r(6, 1, 2);
      imem[9]  = enc_r(1, 4, 5);
      imem[10] = enc_r(6, 4, 1);
      imem[11] = enc_r(1, 6, 3);
      for (int i = 0; i < 5; i++) push(i, 4);
      push(5, 6); push(6, 7);
      for (int i = 7; i < 12; i++) push(i, 4);
      release_reset(0, 2);
      wait_halt(400);
      check("t3_dmem4", 64'(dmem[4]), 64'hDEADBEEF);
      check("t3_r3", 64'(dut.rf[3]), 64'hDEADBEEF);
      check("t3_r6", 64'(dut.rf[6]), 64'h000000D0);
      check("t3_r1", 64'(dut.rf[1]), 64'h0000DE7D);
      check("t3_stable", 64'(stab_err), 64'd0);

      // Branches: B, BL, BZ not-taken, BR, BZ taken; r0 write discarded.
      start_reset();
      imem[0]  = enc_i(1, 0, 7, 1);
      imem[1]  = enc_j(5, 8);
      imem[10] = enc_j(6, 3);
      imem[14] = enc_i(4, 7, 0, 5);
      imem[15] = enc_i(7, 31, 0, 0);
      imem[11] = enc_i(1, 0, 0, 1);
      imem[12] = enc_i(4, 0, 0, 7);
      push(0, 4); push(1, 4); push(10, 4); push(14, 4); push(15, 4); push(11, 4); push(12, 4);
      release_reset(0, 0);
      wait_halt(400);
      check("t4_r31", 64'(dut.rf[31]), 64'd11);
      check("t4_r0", 64'(dut.rf[0]), 64'd0);
      check("t4_pc", 64'(pc_out), 64'd20);
      check("t4_trap", 64'(trap), 64'd0);

      // Illegal opcode 9.
      start_reset();
      imem[0] = enc_i(1, 0, 2, 3);
      imem[1] = {6'd9, 26'd0};
      push(0, 4);
      release_reset(0, 0);
      wait_halt(200);
      check("t5_trap", 64'(trap), 64'd1);
      check("t5_pc", 64'(pc_out), 64'd1);
      check("t5_r2", 64'(dut.rf[2]), 64'd3);

      // Illegal R-type func 6.
      start_reset();
      imem[0] = enc_r(1, 2, 6);
      release_reset(0, 0);
      wait_halt(200);
      check("t6_trap", 64'(trap), 64'd1);

      // Reset asserted while a load waits in MEM.
      start_reset();
      imem[0] = enc_i(1, 0, 1, 9);
      imem[1] = enc_i(2, 0, 2, 0);
      dmem[0] = 32'h1234;
      push(0, 4);
      release_reset(0, 10);
      n = 0;
      while (!dmem_req && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("t7_dreq_seen", 64'(dmem_req), 64'd1);
      @(negedge clk);
      #2 reset = 1'b0;
      #1;
      check("t7_dreq_drop", 64'(dmem_req), 64'd0);
      check("t7_ireq_drop", 64'(imem_req), 64'd0);
      sb.delete();
      started = 0;
      @(negedge clk);
      force_dr = 1;
      @(negedge clk);
      check("t7_no_retire", 64'(retire), 64'd0);
      force_dr = 0;
      ddelay = 0;
      push(0, 4); push(1, 5);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("t7_pc0", 64'(pc_out), 64'd0);
      check("t7_r1_cleared", 64'(dut.rf[1]), 64'd0);
      check("t7_ireq_low", 64'(imem_req), 64'd0);
      @(posedge clk);
      #2;
      check("t7_ireq_rise", 64'(imem_req), 64'd1);
      wait_halt(200);
      check("t7_r1", 64'(dut.rf[1]), 64'd9);
      check("t7_r2", 64'(dut.rf[2]), 64'h1234);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
